// File: rtl/idli_decode_queue_m.sv
// Decode queue: assembles SQI slices into instruction words, pre-classifies them and buffers DEPTH entries.
// Optional macro IDLI_DECODE_QUEUE_BYPASS_EN adds a same-cycle path from a completing word to an empty queue's outputs.
package idli_decode_queue_pkg;
  typedef enum logic [1:0] {
    PIPE_ALU   = 2'd0,
    PIPE_SHIFT = 2'd1,
    PIPE_IO    = 2'd2,
    PIPE_COUNT = 2'd3
  } pipe_t;
endpackage

module idli_decode_queue_m
  import idli_decode_queue_pkg::*;
#(
  parameter int WORD_W  = 16,
  parameter int SLICE_W = 4,
  parameter int DEPTH   = 4
) (
  input  logic                       i_dq_gck,
  input  logic                       i_dq_rst,
  input  logic                       i_dq_flush,
  input  logic [SLICE_W-1:0]         i_dq_slice,
  input  logic                       i_dq_slice_vld,
  output logic                       o_dq_slice_rdy,
  output logic                       o_dq_vld,
  input  logic                       i_dq_rdy,
  output logic [WORD_W-1:0]          o_dq_enc,
  output pipe_t                      o_dq_pipe,
  output logic                       o_dq_imm,
  output logic [$clog2(DEPTH+1)-1:0] o_dq_count
);
  localparam int NSL = WORD_W / SLICE_W;
  localparam int SCW = (NSL > 1) ? $clog2(NSL) : 1;
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);

  logic [WORD_W-1:0] mem_enc [DEPTH];
  pipe_t             mem_pipe[DEPTH];
  logic              mem_imm [DEPTH];

  logic [CW-1:0]     count;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [SCW-1:0]    slice_cnt;
  logic [WORD_W-1:0] shreg;
  logic              imm_pending;
  logic [WORD_W-1:0] enc_q;
  pipe_t             pipe_q;
  logic              imm_q;

  logic              slice_acc, word_done, head_vld, byp, byp_take, push, pop;
  logic [WORD_W-1:0] word_next;
  pipe_t             new_pipe;

  // Nibble fields: op = slice 0, s1..s3 = following slices.
  function automatic pipe_t classify(input logic [WORD_W-1:0] w);
    logic [3:0] op, s1, s3;
    op = w[WORD_W-1 -: 4];
    s1 = w[WORD_W-1-SLICE_W -: 4];
    s3 = w[WORD_W-1-3*SLICE_W -: 4];
    if (op == 4'b1010 && (s3[3:1] == 3'b101 || s3[3:1] == 3'b110)) return PIPE_SHIFT;
    if (op == 4'b1101 && !s1[0]) return PIPE_IO;
    if (op == 4'b1110 && s1[0]) return PIPE_COUNT;
    return PIPE_ALU;
  endfunction

  function automatic logic sets_imm(input logic [WORD_W-1:0] w);
    logic [3:0] op, s2, s3;
    op = w[WORD_W-1 -: 4];
    s2 = w[WORD_W-1-2*SLICE_W -: 4];
    s3 = w[WORD_W-1-3*SLICE_W -: 4];
    return (s3 == 4'hF) && (op[3:1] != 3'b100) && !(op == 4'b1101 && !s2[0]);
  endfunction

  assign o_dq_slice_rdy = (count < CW'(DEPTH));
  assign o_dq_count     = count;
  assign slice_acc      = i_dq_slice_vld && o_dq_slice_rdy && !i_dq_flush;
  assign word_done      = slice_acc && (slice_cnt == SCW'(NSL - 1));
  assign word_next      = {shreg[WORD_W-SLICE_W-1:0], i_dq_slice};
  assign new_pipe       = imm_pending ? PIPE_ALU : classify(word_next);
  assign head_vld       = (count != '0);

`ifdef IDLI_DECODE_QUEUE_BYPASS_EN
  assign byp = word_done && !head_vld;
`else
  assign byp = 1'b0;
`endif

  assign byp_take = byp && i_dq_rdy;
  assign push     = word_done && !byp_take;
  assign pop      = head_vld && i_dq_rdy && !i_dq_flush;
  assign o_dq_vld = head_vld || byp;

  // Outputs hold the last presented entry when nothing is valid.
  always_comb begin
    o_dq_enc  = enc_q;
    o_dq_pipe = pipe_q;
    o_dq_imm  = imm_q;
    if (head_vld) begin
      o_dq_enc  = mem_enc[rd_ptr];
      o_dq_pipe = mem_pipe[rd_ptr];
      o_dq_imm  = mem_imm[rd_ptr];
    end else if (byp) begin
      o_dq_enc  = word_next;
      o_dq_pipe = new_pipe;
      o_dq_imm  = imm_pending;
    end
  end

  always_ff @(posedge i_dq_gck) begin
    if (push && !i_dq_rst) begin
      mem_enc[wr_ptr]  <= word_next;
      mem_pipe[wr_ptr] <= new_pipe;
      mem_imm[wr_ptr]  <= imm_pending;
    end
  end

  always_ff @(posedge i_dq_gck) begin
    if (i_dq_rst) begin
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      slice_cnt   <= '0;
      shreg       <= '0;
      imm_pending <= 1'b0;
      enc_q       <= '0;
      pipe_q      <= PIPE_ALU;
      imm_q       <= 1'b0;
    end else begin
      enc_q  <= o_dq_enc;
      pipe_q <= o_dq_pipe;
      imm_q  <= o_dq_imm;
      if (i_dq_flush) begin
        count       <= '0;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        slice_cnt   <= '0;
        imm_pending <= 1'b0;
      end else begin
        if (slice_acc) begin
          shreg     <= word_next;
          slice_cnt <= word_done ? '0 : slice_cnt + 1'b1;
        end
        if (word_done) imm_pending <= imm_pending ? 1'b0 : sets_imm(word_next);
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_idli_decode_queue_m.sv
// Randomized bench for idli_decode_queue_m against a queue-based reference model.
module tb_idli_decode_queue_m;
  import idli_decode_queue_pkg::*;
  localparam int DEPTH = 4;
`ifdef IDLI_DECODE_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, slice_vld, slice_rdy, vld, rdy, imm;
  logic [3:0]  slice;
  logic [15:0] enc;
  pipe_t       pipe;
  logic [2:0]  count;

  always #5 clk = ~clk;

  idli_decode_queue_m #(.WORD_W(16), .SLICE_W(4), .DEPTH(DEPTH)) dut (
    .i_dq_gck(clk), .i_dq_rst(rst), .i_dq_flush(flush),
    .i_dq_slice(slice), .i_dq_slice_vld(slice_vld), .o_dq_slice_rdy(slice_rdy),
    .o_dq_vld(vld), .i_dq_rdy(rdy), .o_dq_enc(enc), .o_dq_pipe(pipe),
    .o_dq_imm(imm), .o_dq_count(count)
  );

  typedef struct {
    logic [15:0] enc;
    pipe_t       pipe;
    logic        imm;
  } ent_t;

  ent_t        q[$];
  int          nsl;
  logic [15:0] part;
  bit          pend;
  logic [15:0] last_enc;
  pipe_t       last_pipe;
  logic        last_imm;
  bit          armed = 1'b0;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic pipe_t ref_class(input logic [15:0] w);
    logic [3:0] op, s1, s3;
    op = w[15:12];
    s1 = w[11:8];
    s3 = w[3:0];
    if (op == 4'hA && (s3 inside {4'hA, 4'hB, 4'hC, 4'hD})) return PIPE_SHIFT;
    if (op == 4'hD && s1[0] == 1'b0) return PIPE_IO;
    if (op == 4'hE && s1[0] == 1'b1) return PIPE_COUNT;
    return PIPE_ALU;
  endfunction

  function automatic bit ref_sets_imm(input logic [15:0] w);
    logic [3:0] op, s2, s3;
    op = w[15:12];
    s2 = w[7:4];
    s3 = w[3:0];
    if (s3 != 4'hF) return 1'b0;
    if (op == 4'h8 || op == 4'h9) return 1'b0;
    if (op == 4'hD && s2[0] == 1'b0) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: drive inputs at negedge, check outputs, advance the model.
  task automatic cyc(input bit sv, input logic [3:0] sl, input bit rd, input bit fl, input bit rs);
    bit          acc, done, byp, take, ev;
    ent_t        e;
    logic [15:0] w, ee;
    pipe_t       ep;
    logic        ei;
    slice_vld = sv; slice = sl; rdy = rd; flush = fl; rst = rs;
    #1;
    acc    = sv && !fl && (q.size() < DEPTH);
    w      = {part[11:0], sl};
    done   = acc && (nsl == 3);
    e.enc  = w;
    e.imm  = pend;
    e.pipe = pend ? PIPE_ALU : ref_class(w);
    byp    = BYP && done && (q.size() == 0);
    ev     = (q.size() > 0) || byp;
    if (q.size() > 0) begin
      ee = q[0].enc; ep = q[0].pipe; ei = q[0].imm;
    end else if (byp) begin
      ee = e.enc; ep = e.pipe; ei = e.imm;
    end else begin
      ee = last_enc; ep = last_pipe; ei = last_imm;
    end
    if (armed && !rs) begin
      chk("vld", 32'(vld), 32'(ev));
      chk("count", 32'(count), 32'(q.size()));
      chk("slice_rdy", 32'(slice_rdy), 32'(q.size() < DEPTH));
      chk("enc", 32'(enc), 32'(ee));
      chk("pipe", 32'(pipe), 32'(ep));
      chk("imm", 32'(imm), 32'(ei));
    end
    if (rs) begin
      armed = 1'b1;
      q.delete();
      nsl = 0; part = '0; pend = 1'b0;
      last_enc = '0; last_pipe = PIPE_ALU; last_imm = 1'b0;
    end else begin
      last_enc = ee; last_pipe = ep; last_imm = ei;
      if (fl) begin
        q.delete();
        nsl = 0; pend = 1'b0;
      end else begin
        take = byp && rd;
        if (q.size() > 0 && rd) void'(q.pop_front());
        if (acc) begin
          part = w;
          nsl  = done ? 0 : nsl + 1;
        end
        if (done) begin
          pend = pend ? 1'b0 : ref_sets_imm(w);
          if (!take) q.push_back(e);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [15:0] w, input bit rd);
    for (int k = 0; k < 4; k++) cyc(1'b1, w[15-4*k -: 4], rd, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n, input bit rd);
    for (int k = 0; k < n; k++) cyc(1'b0, 4'h0, rd, 1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0] pick [8];
    pick = '{4'h0, 4'h1, 4'h2, 4'hA, 4'hD, 4'hE, 4'hF, 4'h0};
    rst = 1'b1; flush = 1'b0; slice_vld = 1'b0; slice = '0; rdy = 1'b0;
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    idle(1, 1'b1);
    send(16'h0012, 1'b1); idle(3, 1'b1);
    send(16'hA00A, 1'b0); send(16'hFFFF, 1'b0); idle(4, 1'b1);
    send(16'h012F, 1'b1); send(16'h1234, 1'b1); send(16'h0000, 1'b1); idle(3, 1'b1);
    send(16'hD012, 1'b0); send(16'hE1F0, 1'b0); send(16'hA00C, 1'b0); send(16'h5555, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b1, 4'h7, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 4'h7, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 4'h8, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    send(16'h9876, 1'b0); idle(8, 1'b1);
    send(16'h5670, 1'b0); send(16'h012F, 1'b0);
    cyc(1'b1, 4'h3, 1'b0, 1'b0, 1'b0); cyc(1'b1, 4'h4, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 4'h5, 1'b1, 1'b1, 1'b0);
    send(16'h0012, 1'b1); idle(2, 1'b1);
    send(16'hD000, 1'b1); idle(2, 1'b1);
    send(16'hD000, 1'b0); idle(2, 1'b1);
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] sl;
      sl = ($urandom_range(0, 9) < 8) ? pick[$urandom_range(0, 7)] : 4'($urandom);
      cyc($urandom_range(0, 9) < 7, sl, $urandom_range(0, 9) < 6,
          $urandom_range(0, 99) < 2, $urandom_range(0, 199) == 0);
    end
    idle(6, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
